// File: rtl/sample_dispatch_if.sv
// Sample dispatch handshake bundle: loader input, filter output, batch control and occupancy.
// master = host/loader/filter side, slave = sample_dispatch.
interface sample_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clear;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cnt_up;
  logic              batch_done;
  logic              batch_ack;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output clear, in_data, in_valid, out_ready, batch_ack,
    input  in_ready, out_data, out_valid, cnt_up, batch_done, fifo_count
  );

  modport slave (
    input  clear, in_data, in_valid, out_ready, batch_ack,
    output in_ready, out_data, out_valid, cnt_up, batch_done, fifo_count
  );
endinterface

// File: rtl/sample_dispatch.sv
// Sample FIFO feeding the filter, with per-transfer cnt_up and batch hold/ack.
// Optional SAMPLE_DISPATCH_STATS_EN adds batch_total (completed batches, cleared by rst only).
module sample_dispatch #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int BATCH  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  sample_dispatch_if.slave  bus
`ifdef SAMPLE_DISPATCH_STATS_EN
  ,
  output logic [15:0]       batch_total
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int BW    = $clog2(BATCH + 1);
  localparam logic [BW-1:0] BATCH_LAST = BW'(BATCH - 1);

  typedef enum logic {RUN, HOLD} state_e;

  state_e            state_q;
  logic [BW-1:0]     bcnt_q;
  logic              batch_done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic flush, push, pop, out_valid, in_ready, batch_end;

  assign flush     = rst | bus.clear;
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0) && (state_q == RUN);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign batch_end = pop && (bcnt_q == BATCH_LAST);

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.cnt_up     = pop;
  assign bus.batch_done = batch_done_q;
  assign bus.fifo_count = count_q;

  // Storage has no reset; a flushed push may still write, but the pointers discard it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q      <= RUN;
      bcnt_q       <= '0;
      batch_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (batch_end) begin
            bcnt_q       <= '0;
            state_q      <= HOLD;
            batch_done_q <= 1'b1;
          end else if (pop) begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        HOLD: begin
          if (bus.batch_ack) begin
            state_q      <= RUN;
            batch_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          batch_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_DISPATCH_STATS_EN
  logic [15:0] batch_total_q;

  // A batch-ending pop coincident with clear does not enter HOLD, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      batch_total_q <= '0;
    end else if (!bus.clear && batch_end) begin
      batch_total_q <= batch_total_q + 16'd1;
    end
  end

  assign batch_total = batch_total_q;
`endif
endmodule

// File: tb/tb_sample_dispatch.sv
// Randomized and directed checks of sample_dispatch against a queue-based batch model.
module tb_sample_dispatch;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int BT = 4;
  localparam int CW = $clog2(DP) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_dispatch_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

`ifdef SAMPLE_DISPATCH_STATS_EN
  logic [15:0] batch_total;
  int unsigned total;
  sample_dispatch #(.DATA_W(DW), .DEPTH(DP), .BATCH(BT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .batch_total(batch_total));
`else
  sample_dispatch #(.DATA_W(DW), .DEPTH(DP), .BATCH(BT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model: queue contents, deliveries in current batch, waiting-for-ack flag.
  logic [DW-1:0] q[$];
  int            bcnt = 0;
  bit            hold = 1'b0;

  bit            e_ir, e_ov, e_cu, e_bd;
  int            e_cnt;
  logic [DW-1:0] e_data;

  task automatic drive(input bit r, input bit clr, input bit iv, input logic [DW-1:0] d,
                       input bit ordy, input bit ack);
    rst = r; bus.clear = clr; bus.in_valid = iv; bus.in_data = d;
    bus.out_ready = ordy; bus.batch_ack = ack;
    e_cnt  = q.size();
    e_ir   = (e_cnt != DP);
    e_ov   = (e_cnt != 0) && !hold;
    e_cu   = e_ov && ordy;
    e_bd   = hold;
    e_data = e_ov ? q[0] : '0;
    @(negedge clk);
  endtask

  task automatic advance();
    bit            push, pop;
    logic [DW-1:0] d;
    push = bus.in_valid && e_ir;
    pop  = e_cu;
    d    = bus.in_data;
    @(posedge clk);
    if (rst || bus.clear) begin
      q.delete(); bcnt = 0; hold = 1'b0;
`ifdef SAMPLE_DISPATCH_STATS_EN
      if (rst) total = 0;
`endif
    end else begin
      if (hold) begin
        if (bus.batch_ack) hold = 1'b0;
      end else if (pop) begin
        void'(q.pop_front());
        bcnt++;
        if (bcnt == BT) begin
          bcnt = 0; hold = 1'b1;
`ifdef SAMPLE_DISPATCH_STATS_EN
          total = (total + 1) % 65536;
`endif
        end
      end
      if (push) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, '0, 0, 0); advance();
    drive(0, 0, 0, '0, 0, 0);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {4'b1000, CW'(0)}) begin
      fails++;
      $display("FAIL reset_state: got ir/ov/cu/bd/cnt=%b required %b",
        {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {4'b1000, CW'(0)});
    end
    advance();
  endtask

  task automatic test_single();
    drive(0, 1, 0, '0, 0, 0); advance();
    drive(0, 0, 1, 16'h1234, 1, 0);
    checks++;
    if (bus.cnt_up !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL single_c0: got ov=%b cu=%b required 0 0", bus.out_valid, bus.cnt_up);
    end
    advance();
    drive(0, 0, 0, '0, 1, 0);
    checks++;
    if ({bus.out_valid, bus.cnt_up, bus.fifo_count, bus.out_data} !== {2'b11, CW'(1), 16'h1234}) begin
      fails++; $display("FAIL single_c1: got ov=%b cu=%b cnt=%0d data=%h required 1 1 1 1234",
        bus.out_valid, bus.cnt_up, bus.fifo_count, bus.out_data);
    end
    advance();
    drive(0, 0, 0, '0, 1, 0);
    checks++;
    if ({bus.out_valid, bus.cnt_up, bus.fifo_count} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL single_c2: got ov=%b cu=%b cnt=%0d required 0 0 0",
        bus.out_valid, bus.cnt_up, bus.fifo_count);
    end
    advance();
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    drive(0, 1, 0, '0, 0, 0); advance();
    for (int i = 0; i < 5; i++) begin
      d = DW'($urandom);
      drive(0, 0, 1, d, 0, 0);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)}) begin
        fails++; $display("FAIL full_fill[%0d]: got ir/ov/cu/bd/cnt=%b required %b", i,
          {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)});
      end
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, '0, 1, 0);
      if (i == 0) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.fifo_count !== CW'(4)) begin
          fails++; $display("FAIL full_level: got ir=%b cnt=%0d required 0 4", bus.in_ready, bus.fifo_count);
        end
      end
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)}) begin
        fails++; $display("FAIL full_drain[%0d]: got ir/ov/cu/bd/cnt=%b required %b", i,
          {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)});
      end
      if (e_ov) begin
        checks++;
        if (bus.out_data !== e_data) begin
          fails++; $display("FAIL full_order[%0d]: got %h required %h", i, bus.out_data, e_data);
        end
      end
      advance();
    end
    drive(0, 0, 0, '0, 1, 1); advance();
  endtask

  task automatic test_batch();
    int pulses = 0;
    drive(0, 1, 0, '0, 0, 0); advance();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, i < 6, DW'(16'h0A00 + i), 1, 0);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)}) begin
        fails++; $display("FAIL batch_run[%0d]: got ir/ov/cu/bd/cnt=%b required %b", i,
          {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)});
      end
      if (bus.cnt_up === 1'b1) pulses++;
      advance();
    end
    drive(0, 0, 0, '0, 1, 1);
    checks++;
    if (pulses != 4 || bus.batch_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.fifo_count !== CW'(2)) begin
      fails++; $display("FAIL batch_hold: got pulses=%0d bd=%b ov=%b cnt=%0d required 4 1 0 2",
        pulses, bus.batch_done, bus.out_valid, bus.fifo_count);
    end
    advance();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, 1, 0);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)}) begin
        fails++; $display("FAIL batch_ack[%0d]: got ir/ov/cu/bd/cnt=%b required %b", i,
          {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)});
      end
      if (e_ov) begin
        checks++;
        if (bus.out_data !== e_data) begin
          fails++; $display("FAIL batch_data[%0d]: got %h required %h", i, bus.out_data, e_data);
        end
      end
      if (bus.cnt_up === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (pulses != 2) begin
      fails++; $display("FAIL batch_resume: got %0d transfers required 2", pulses);
    end
  endtask

  // Stray ack after 2 deliveries: batch still needs exactly 2 more transfers.
  task automatic test_stray_ack();
    int pulses = 0;
    int seen = 0;
    drive(0, 1, 0, '0, 0, 0); advance();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, (i < 2) || (i >= 5 && i < 7), DW'($urandom), 1, i == 4);
      if (bus.batch_done === 1'b1 && seen == 0) begin
        seen = 1;
        checks++;
        if (pulses != 4) begin
          fails++; $display("FAIL stray_ack: got batch_done after %0d transfers required 4", pulses);
        end
      end
      if (bus.cnt_up === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (seen == 0) begin
      fails++; $display("FAIL stray_ack_timeout: got batch_done=0 within 12 cycles required 1");
    end
  endtask

  task automatic test_clear();
    int pulses = 0;
    int seen = 0;
    drive(0, 1, 0, '0, 0, 0); advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, i != 3, DW'($urandom), i < 4, 0);
      advance();
    end
    drive(0, 1, 0, '0, 0, 0); advance();
    drive(0, 0, 0, '0, 0, 0);
    checks++;
    if ({bus.fifo_count, bus.in_ready, bus.out_valid} !== {CW'(0), 2'b10}) begin
      fails++; $display("FAIL clear_state: got cnt=%0d ir=%b ov=%b required 0 1 0",
        bus.fifo_count, bus.in_ready, bus.out_valid);
    end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, i < 6, DW'($urandom), 1, 0);
      if (bus.batch_done === 1'b1 && seen == 0) begin
        seen = 1;
        checks++;
        if (pulses != 4) begin
          fails++; $display("FAIL clear_batch: got batch_done after %0d transfers required 4", pulses);
        end
      end
      if (bus.cnt_up === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (seen == 0) begin
      fails++; $display("FAIL clear_timeout: got batch_done=0 within 10 cycles required 1");
    end
    drive(0, 1, 0, '0, 0, 0); advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            DW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count} !== {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)}) begin
        fails++; $display("FAIL random_flags[%0d]: got ir/ov/cu/bd/cnt=%b required %b", i,
          {bus.in_ready, bus.out_valid, bus.cnt_up, bus.batch_done, bus.fifo_count}, {e_ir, e_ov, e_cu, e_bd, CW'(e_cnt)});
      end
      if (e_ov) begin
        checks++;
        if (bus.out_data !== e_data) begin
          fails++; $display("FAIL random_data[%0d]: got %h required %h", i, bus.out_data, e_data);
        end
      end
      advance();
    end
  endtask

`ifdef SAMPLE_DISPATCH_STATS_EN
  task automatic test_stats();
    drive(1, 0, 0, '0, 0, 0); advance();
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 1, DW'($urandom), 1, 1);
      checks++;
      if (batch_total !== 16'(total)) begin
        fails++; $display("FAIL stats_count[%0d]: got %0d required %0d", i, batch_total, total);
      end
      advance();
    end
    drive(0, 1, 0, '0, 0, 0); advance();
    drive(0, 0, 0, '0, 0, 0);
    checks++;
    if (total == 0 || batch_total !== 16'(total)) begin
      fails++; $display("FAIL stats_clear: got %0d required %0d (nonzero)", batch_total, total);
    end
    advance();
    drive(1, 0, 0, '0, 0, 0); advance();
    drive(0, 0, 0, '0, 0, 0);
    checks++;
    if (batch_total !== 16'd0) begin
      fails++; $display("FAIL stats_rst: got %0d required 0", batch_total);
    end
    advance();
  endtask
`endif

  initial begin
`ifdef SAMPLE_DISPATCH_STATS_EN
    total = 0;
`endif
    rst = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b0; bus.batch_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_full();
    test_batch();
    test_stray_ack();
    test_clear();
    test_random();
`ifdef SAMPLE_DISPATCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
